// File: rtl/bin_cnt_pkg.sv
// -----------------------------------------------------------------------------
// bin_cnt_pkg
//   Shared types and constants for the loadable binary down-counter.
//   cnt_state_t   : FSM encoding (IDLE / RUN / DONE)
//   CNT_WIDTH_DEF : default counter width
// -----------------------------------------------------------------------------
package bin_cnt_pkg;

    typedef enum logic [1:0] {
        CNT_IDLE,
        CNT_RUN,
        CNT_DONE
    } cnt_state_t;

    localparam int CNT_WIDTH_DEF = 4;

endpackage

// File: rtl/bin_down_counter_if.sv
// -----------------------------------------------------------------------------
// bin_down_counter_if
//   Control/status bundle for bin_down_counter.
//   load      : load request, start value taken from load_val
//   load_val  : start value (WIDTH bits)
//   en        : count enable
//   cnt_out   : current count (registered)
//   tc        : terminal-count pulse (registered, 1 cycle)
//   busy      : counter is in RUN
//   master drives load/load_val/en; slave (the counter) drives the status.
// -----------------------------------------------------------------------------
interface bin_down_counter_if
    import bin_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
);

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] cnt_out;
    logic             tc;
    logic             busy;

    modport master (
        output load,
        output load_val,
        output en,
        input  cnt_out,
        input  tc,
        input  busy
    );

    modport slave (
        input  load,
        input  load_val,
        input  en,
        output cnt_out,
        output tc,
        output busy
    );

endinterface

// File: rtl/bin_down_counter.sv
// -----------------------------------------------------------------------------
// bin_down_counter
//   Loadable binary down-counter / countdown timer. A load captures a start
//   value; each enabled edge in RUN decrements it; reaching zero raises a
//   one-cycle terminal-count pulse.
//
//   Ports:
//     clk  : system clock, all logic on posedge
//     rst  : synchronous active-high reset (overrides load and en)
//     bus  : bin_down_counter_if.slave (load, load_val, en -> cnt_out, tc, busy)
//
//   Parameter WIDTH : counter width, 2..16
//
//   Build option BIN_DOWNCNT_RELOAD_EN:
//     defined   - auto-reload: on 1->0 the counter restarts from the last
//                 loaded value, pulses tc and stays in RUN (DONE unreachable).
//     undefined - one-shot: 1->0 pulses tc, passes through DONE for one
//                 cycle, then returns to IDLE.
//
//   State | Meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped, cnt_out = 0, en ignored
//   RUN   | counting down on en
//   DONE  | single cycle after reaching zero, tc = 1 (one-shot only)
// -----------------------------------------------------------------------------
module bin_down_counter
    import bin_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    bin_down_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic             tc_q,    tc_d;
    logic             busy_q,  busy_d;
`ifdef BIN_DOWNCNT_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CNT_IDLE;
            cnt_q    <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BIN_DOWNCNT_RELOAD_EN
            reload_q <= ZERO;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
`ifdef BIN_DOWNCNT_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Next-state and next-count
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
`ifdef BIN_DOWNCNT_RELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.load) begin
            // load wins over en in every state, including DONE
            cnt_d   = bus.load_val;
            state_d = (bus.load_val != ZERO) ? CNT_RUN : CNT_IDLE;
`ifdef BIN_DOWNCNT_RELOAD_EN
            reload_d = bus.load_val;
`endif
        end else begin
            unique case (state_q)
                CNT_IDLE: begin
                    cnt_d = ZERO;
                end
                CNT_RUN: begin
                    if (bus.en) begin
                        // RUN is only entered with a nonzero count, so the
                        // 1 -> 0 step is the only way out and never underflows
                        if (cnt_q == ONE) begin
                            tc_d = 1'b1;
`ifdef BIN_DOWNCNT_RELOAD_EN
                            cnt_d   = reload_q;
                            state_d = CNT_RUN;
`else
                            cnt_d   = ZERO;
                            state_d = CNT_DONE;
`endif
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
                CNT_DONE: begin
                    cnt_d   = ZERO;
                    state_d = CNT_IDLE;
                end
                default: begin
                    cnt_d   = ZERO;
                    state_d = CNT_IDLE;
                end
            endcase
        end
    end

    // busy is registered from the next state so it lines up with cnt_out
    always_comb begin
        busy_d = (state_d == CNT_RUN);
    end

    assign bus.cnt_out = cnt_q;
    assign bus.tc      = tc_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_bin_down_counter.sv
// -----------------------------------------------------------------------------
// tb_bin_down_counter
//   Directed bench for bin_down_counter at WIDTH=4. Each step drives inputs,
//   waits for one rising edge, then samples cnt_out/tc/busy 1 ns later and
//   compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_bin_down_counter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bin_down_counter_if #(.WIDTH(4)) bus ();

    bin_down_counter #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ec,
                       input logic et, input logic eb);
        checks++;
        assert (bus.cnt_out === ec) else begin
            failures++;
            $error("FAIL %s cnt_out observed=%0d expected=%0d", tag, bus.cnt_out, ec);
        end
        checks++;
        assert (bus.tc === et) else begin
            failures++;
            $error("FAIL %s tc observed=%0b expected=%0b", tag, bus.tc, et);
        end
        checks++;
        assert (bus.busy === eb) else begin
            failures++;
            $error("FAIL %s busy observed=%0b expected=%0b", tag, bus.busy, eb);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        bus.en       = 1'b0;

        // reset state
        step();
        chk("reset", 4'd0, 1'b0, 1'b0);
        // load and en under reset are ignored
        bus.load = 1'b1; bus.load_val = 4'd9; bus.en = 1'b1;
        step();
        chk("reset_ovr_load", 4'd0, 1'b0, 1'b0);
        rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
        step();
        chk("idle_after_rst", 4'd0, 1'b0, 1'b0);

`ifndef BIN_DOWNCNT_RELOAD_EN
        // 1: load 5, en held high
        bus.load = 1'b1; bus.load_val = 4'd5; bus.en = 1'b1;
        step();
        chk("t1_load5", 4'd5, 1'b0, 1'b1);
        bus.load = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            step();
            chk("t1_dec", 4'(i), 1'b0, 1'b1);
        end
        step();
        chk("t1_done_tc", 4'd0, 1'b1, 1'b0);
        step();
        chk("t1_idle", 4'd0, 1'b0, 1'b0);
        step();
        chk("t1_idle_en_ign", 4'd0, 1'b0, 1'b0);

        // 2: load 15 (max), en on alternate cycles
        bus.load = 1'b1; bus.load_val = 4'd15; bus.en = 1'b0;
        step();
        chk("t2_load15", 4'd15, 1'b0, 1'b1);
        bus.load = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            bus.en = 1'b0;
            step();
            chk("t2_hold", 4'(16 - i), 1'b0, 1'b1);
            bus.en = 1'b1;
            step();
            chk("t2_dec", 4'(15 - i), (i == 15), (i != 15));
        end
        bus.en = 1'b0;
        step();
        chk("t2_idle", 4'd0, 1'b0, 1'b0);

        // load accepted during DONE
        bus.load = 1'b1; bus.load_val = 4'd1; bus.en = 1'b1;
        step();
        chk("done_ld_a", 4'd1, 1'b0, 1'b1);
        bus.load = 1'b0;
        step();
        chk("done_ld_tc", 4'd0, 1'b1, 1'b0);
        bus.load = 1'b1; bus.load_val = 4'd2; bus.en = 1'b0;
        step();
        chk("done_ld_run", 4'd2, 1'b0, 1'b1);
        bus.load = 1'b0; bus.en = 1'b1;
        step();
        chk("done_ld_dec", 4'd1, 1'b0, 1'b1);
        step();
        chk("done_ld_tc2", 4'd0, 1'b1, 1'b0);
        step();
        chk("done_ld_idle", 4'd0, 1'b0, 1'b0);
`else
        // 6: auto-reload, load 4 with en held high
        bus.load = 1'b1; bus.load_val = 4'd4; bus.en = 1'b1;
        step();
        chk("t6_load4", 4'd4, 1'b0, 1'b1);
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_seq", 4'(3 - (i % 4)) == 4'd0 ? 4'd4 : 4'(3 - (i % 4)),
                (i % 4) == 3, 1'b1);
        end
        bus.load = 1'b1; bus.load_val = 4'd0;
        step();
        chk("t6_stop", 4'd0, 1'b0, 1'b0);
        bus.load = 1'b0;
        step();
        chk("t6_idle", 4'd0, 1'b0, 1'b0);
`endif

        // 3: reload mid-count, then load 0
        bus.load = 1'b1; bus.load_val = 4'd15; bus.en = 1'b1;
        step();
        chk("t3_load15", 4'd15, 1'b0, 1'b1);
        bus.load = 1'b0;
        for (int i = 14; i >= 9; i--) begin
            step();
            chk("t3_dec", 4'(i), 1'b0, 1'b1);
        end
        bus.load = 1'b1; bus.load_val = 4'd3;
        step();
        chk("t3_restart3", 4'd3, 1'b0, 1'b1);
        bus.load = 1'b0;
        step();
        chk("t3_dec2", 4'd2, 1'b0, 1'b1);
        bus.load = 1'b1; bus.load_val = 4'd0;
        step();
        chk("t3_load0", 4'd0, 1'b0, 1'b0);
        bus.load = 1'b0;
        step();
        chk("t3_idle_no_tc", 4'd0, 1'b0, 1'b0);

        // 4: load and en on the same edge
        bus.load = 1'b1; bus.load_val = 4'd7; bus.en = 1'b1;
        step();
        chk("t4_load_pri", 4'd7, 1'b0, 1'b1);
        bus.load = 1'b0;
        step();
        chk("t4_dec", 4'd6, 1'b0, 1'b1);

        // 5: reset mid-count at 6, with load asserted
        rst = 1'b1; bus.load = 1'b1; bus.load_val = 4'd9;
        step();
        chk("t5_rst_mid", 4'd0, 1'b0, 1'b0);
        rst = 1'b0; bus.load = 1'b0;
        step();
        chk("t5_after_rst", 4'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
